dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (CPU load/store stage, default priority) and port 1 (DMA/debug loader).
- Arbitration is fixed-priority with a starvation guard.
- Grants one access per cycle, drives the data memory control/address/data inputs, and returns registered read data with a one-cycle valid pulse.
- Rejects misaligned accesses without touching memory.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 has priority; port 1 is forced through after repeated denials.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_maskmode,
  input  logic                  p0_sext,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_maskmode,
  input  logic                  p1_sext,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  win1;
  logic                  gnt0, gnt1, any_gnt;
  logic                  sel_we;
  logic [1:0]            sel_mode;
  logic                  sel_sext;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  misal;

  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic                  p0_err_q, p0_err_d;
  logic                  p1_err_q, p1_err_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

  // Pick the winner: p1 only when alone or when it has starved long enough
  always_comb begin
    win1    = p1_req & (~p0_req | (cnt_q == LIMIT));
    gnt1    = win1 & ~rst;
    gnt0    = p0_req & ~win1 & ~rst;
    any_gnt = gnt0 | gnt1;
  end

  // Mux the winning request and check its alignment
  always_comb begin
    sel_we    = 1'b0;
    sel_mode  = 2'b00;
    sel_sext  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = p1_we;
      sel_mode  = p1_maskmode;
      sel_sext  = p1_sext;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else if (gnt0) begin
      sel_we    = p0_we;
      sel_mode  = p0_maskmode;
      sel_sext  = p0_sext;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
    if (sel_mode[1])
      misal = sel_addr[1:0] != 2'b00;
    else if (sel_mode[0])
      misal = sel_addr[0];
    else
      misal = 1'b0;
  end

  // Memory strobes only fire for aligned grants
  always_comb begin
    mem_address    = sel_addr;
    mem_maskmode   = sel_mode;
    mem_sext       = sel_sext;
    mem_write_data = sel_wdata;
    mem_write      = any_gnt & ~misal & sel_we;
    mem_read       = any_gnt & ~misal & ~sel_we;
  end

  // Starvation counter: counts p1 denials, saturating at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!p1_req || gnt1)
      cnt_d = '0;
    else if (cnt_q != LIMIT)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Completion side: one-cycle pulse, load data or zero on error
  always_comb begin
    p0_rvalid_d = gnt0;
    p1_rvalid_d = gnt1;
    p0_err_d    = gnt0 & misal;
    p1_err_d    = gnt1 & misal;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (gnt0 && misal)
      p0_rdata_d = '0;
    else if (gnt0 && !sel_we)
      p0_rdata_d = mem_read_data;
    if (gnt1 && misal)
      p1_rdata_d = '0;
    else if (gnt1 && !sel_we)
      p1_rdata_d = mem_read_data;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word memory model
// written on negedge and read combinationally.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_sext;
  logic [1:0]  p0_maskmode;
  logic [31:0] p0_addr, p0_wdata;
  logic        p1_req, p1_we, p1_sext;
  logic [1:0]  p1_maskmode;
  logic [31:0] p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic        mem_write, mem_read, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(32), .STARVE_LIMIT(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_maskmode(p0_maskmode),
    .p0_sext(p0_sext), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_maskmode(p1_maskmode),
    .p1_sext(p1_sext), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_maskmode(mem_maskmode), .mem_sext(mem_sext),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:2]];

  always @(negedge clk)
    if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  task automatic set_p0(input logic r, input logic w, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_we = w; p0_maskmode = m; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_we = w; p1_maskmode = m; p1_addr = a; p1_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_p0(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    set_p1(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    p0_sext = 1'b0; p1_sext = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (p0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt: got %b want 0", p0_gnt);
    end
    n_checks++;
    if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000",
        {p0_rvalid, p1_rvalid, p0_err, p1_err});
    end
    n_checks++;
    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h/%h want 0", p0_rdata, p1_rdata);
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem: got %b%b want 00", mem_read, mem_write);
    end
    p0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load();
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    n_checks++;
    if (p0_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL load_gnt: got gnt=%b rd=%b wr=%b want 1 1 0",
        p0_gnt, mem_read, mem_write);
    end
    n_checks++;
    if (mem_address !== 32'h10) begin
      n_fail++; $display("FAIL load_addr: got %h want 00000010", mem_address);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    n_checks++;
    if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_data: got v=%b e=%b d=%h want 1 0 deadbeef",
        p0_rvalid, p0_err, p0_rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_hold: got v=%b d=%h want 0 deadbeef",
        p0_rvalid, p0_rdata);
    end
  endtask

  task automatic test_starve();
    logic e1, prev1;
    prev1 = 1'b0;
    set_p0(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    set_p1(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      else #1;
      e1 = (i % 5) == 4;
      n_checks++;
      if (p0_gnt !== !e1 || p1_gnt !== e1) begin
        n_fail++; $display("FAIL starve_gnt[%0d]: got p0=%b p1=%b want p0=%b p1=%b",
          i, p0_gnt, p1_gnt, !e1, e1);
      end
      if (i > 0) begin
        n_checks++;
        if (p1_rvalid !== prev1 || p0_rvalid !== !prev1) begin
          n_fail++; $display("FAIL starve_rv[%0d]: got p0=%b p1=%b want p0=%b p1=%b",
            i, p0_rvalid, p1_rvalid, !prev1, prev1);
        end
      end
      prev1 = e1;
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    n_checks++;
    if (p1_rdata !== 32'h11112222) begin
      n_fail++; $display("FAIL starve_p1data: got %h want 11112222", p1_rdata);
    end
  endtask

  task automatic test_store_then_load();
    @(posedge clk); #1;
    set_p1(1'b1, 1'b1, 2'b10, 32'h20, 32'hCAFEF00D);
    #1;
    n_checks++;
    if (p1_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL store_gnt: got gnt=%b wr=%b rd=%b want 1 1 0",
        p1_gnt, mem_write, mem_read);
    end
    @(posedge clk); #1;
    p1_req = 1'b0;
    set_p0(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    #1;
    n_checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h11112222 || p0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL store_done: got v=%b d=%h g0=%b want 1 11112222 1",
        p1_rvalid, p1_rdata, p0_gnt);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    n_checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hCAFEF00D || p1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL store_readback: got v=%b d=%h v1=%b want 1 cafef00d 0",
        p0_rvalid, p0_rdata, p1_rvalid);
    end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 2'b01, 32'h13, 32'h0);
    #1;
    n_checks++;
    if (p0_gnt !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL mis_gnt: got gnt=%b rd=%b wr=%b want 1 0 0",
        p0_gnt, mem_read, mem_write);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    set_p1(1'b1, 1'b1, 2'b10, 32'h22, 32'h55555555);
    #1;
    n_checks++;
    if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mis_resp: got v=%b e=%b d=%h want 1 1 0",
        p0_rvalid, p0_err, p0_rdata);
    end
    n_checks++;
    if (p1_gnt !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL mis_store: got gnt=%b wr=%b want 1 0", p1_gnt, mem_write);
    end
    @(posedge clk); #1;
    p1_req = 1'b0;
    n_checks++;
    if (p1_err !== 1'b1 || p1_rvalid !== 1'b1 || mem[8] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL mis_store_resp: got e=%b v=%b m=%h want 1 1 cafef00d",
        p1_err, p1_rvalid, mem[8]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (p0_err !== 1'b0 || p1_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_err_clear: got %b%b want 00", p0_err, p1_err);
    end
  endtask

  task automatic test_reset_mid();
    logic e1;
    @(posedge clk); #1;
    set_p1(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    @(posedge clk); #1;
    p1_req = 1'b0;
    n_checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rm_pre: got v=%b d=%h want 1 deadbeef", p1_rvalid, p1_rdata);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_clear: got v=%b d=%h want 0 0", p1_rvalid, p1_rdata);
    end
    #1 rst = 1'b0;
    p1_req = 1'b1;
    #1;
    n_checks++;
    if (p1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rm_first_gnt: got %b want 1", p1_gnt);
    end
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    set_p1(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rm_gnt_in_rst: got %b%b want 00", p0_gnt, p1_gnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      else #1;
      e1 = (i == 4);
      n_checks++;
      if (p0_gnt !== !e1 || p1_gnt !== e1) begin
        n_fail++; $display("FAIL rm_cnt[%0d]: got p0=%b p1=%b want p0=%b p1=%b",
          i, p0_gnt, p1_gnt, !e1, e1);
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write} !== 6'b0) begin
        n_fail++; $display("FAIL idle_ctl[%0d]: got %b want 000000", i,
          {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write});
      end
      n_checks++;
      if (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'h11112222) begin
        n_fail++; $display("FAIL idle_hold[%0d]: got %h/%h want deadbeef/11112222",
          i, p0_rdata, p1_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[16] = 32'h11112222;
    test_reset();
    test_load();
    test_starve();
    test_store_then_load();
    test_misaligned();
    test_reset_mid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
